// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared types and constants for the CPU fetch front end
package cpu_pkg;

    localparam int unsigned PC_W = 16;

    // Fetch sequencer states
    typedef enum logic [1:0] {
        ST_BOOT   = 2'd0,
        ST_FETCH  = 2'd1,
        ST_DRAIN  = 2'd2,
        ST_HALTED = 2'd3
    } seq_state_t;

    // Branch condition codes
    localparam logic [2:0] COND_NE     = 3'b000;
    localparam logic [2:0] COND_EQ     = 3'b001;
    localparam logic [2:0] COND_GT     = 3'b010;
    localparam logic [2:0] COND_LT     = 3'b011;
    localparam logic [2:0] COND_GE     = 3'b100;
    localparam logic [2:0] COND_LE     = 3'b101;
    localparam logic [2:0] COND_OVF    = 3'b110;
    localparam logic [2:0] COND_UNCOND = 3'b111;

    // Bit positions inside the {Z,V,N} flag vector
    localparam int unsigned FLAG_Z = 2;
    localparam int unsigned FLAG_V = 1;
    localparam int unsigned FLAG_N = 0;

endpackage

// File: rtl/branch_cond_eval.sv
// rtl/branch_cond_eval.sv - decides whether a conditional branch is taken
// Ports:
//   br_cond - 3-bit condition code
//   flags   - {Z,V,N} flag register
//   taken   - condition satisfied
module branch_cond_eval
    import cpu_pkg::*;
(
    input  logic [2:0] br_cond,
    input  logic [2:0] flags,
    output logic       taken
);

    logic z;
    logic v;
    logic n;

    assign z = flags[FLAG_Z];
    assign v = flags[FLAG_V];
    assign n = flags[FLAG_N];

    always_comb begin
        taken = 1'b0;
        case (br_cond)
            COND_NE:     taken = ~z;
            COND_EQ:     taken = z;
            COND_GT:     taken = ~z & ~n;
            COND_LT:     taken = n;
            COND_GE:     taken = z | ~n;
            COND_LE:     taken = n | z;
            COND_OVF:    taken = v;
            COND_UNCOND: taken = 1'b1;
            default:     taken = 1'b0;
        endcase
    end

endmodule

// File: rtl/pc_sequencer.sv
// rtl/pc_sequencer.sv - program counter and instruction fetch sequencer
// Ports:
//   clk, rst                 - clock, async active-low reset
//   imem_req/addr/valid      - instruction memory fetch handshake
//   stall, halt              - decode back-pressure and HLT
//   br_valid/cond/offset/pc_plus2, flags - conditional branch resolve
//   jr_valid, jr_target      - register jump resolve
//   pc_out, pc_plus2         - current PC and its sequential successor
//   inst_valid               - fetched word accepted by decode
//   redirect                 - flush younger instructions (combinational)
//   halted                   - sequencer frozen until reset
module pc_sequencer
    import cpu_pkg::*;
#(
    parameter logic [PC_W-1:0] RESET_PC = 16'h0000,
    parameter int unsigned     PC_STEP  = 2
)
(
    input  logic            clk,
    input  logic            rst,
    output logic            imem_req,
    output logic [PC_W-1:0] imem_addr,
    input  logic            imem_valid,
    input  logic            stall,
    input  logic            halt,
    input  logic            br_valid,
    input  logic [2:0]      br_cond,
    input  logic [8:0]      br_offset,
    input  logic [PC_W-1:0] br_pc_plus2,
    input  logic [2:0]      flags,
    input  logic            jr_valid,
    input  logic [PC_W-1:0] jr_target,
    output logic [PC_W-1:0] pc_out,
    output logic [PC_W-1:0] pc_plus2,
    output logic            inst_valid,
    output logic            redirect,
    output logic            halted
);

    localparam logic [PC_W-1:0] STEP = PC_W'(PC_STEP);

    seq_state_t      state;
    logic [PC_W-1:0] pc;
    logic [PC_W-1:0] drain_addr;  // address of the request still outstanding after a redirect
    logic            halt_pend;   // halt seen while draining; freeze once the drain completes

    logic            br_taken;
    logic            active;
    logic            block;
    logic            take_jr;
    logic            take_br;
    logic [PC_W-1:0] br_target;
    logic [PC_W-1:0] jr_aligned;
    logic [PC_W-1:0] redirect_pc;

    branch_cond_eval u_cond (
        .br_cond (br_cond),
        .flags   (flags),
        .taken   (br_taken)
    );

    // Word offset is sign-extended and scaled to bytes; the sum wraps naturally
    assign br_target  = br_pc_plus2 + {{6{br_offset[8]}}, br_offset, 1'b0};
    assign jr_aligned = {jr_target[PC_W-1:1], 1'b0};

    assign active = (state == ST_FETCH) || (state == ST_DRAIN);
    // Once halt is seen, no further control flow changes are honoured
    assign block  = halt || halt_pend;

    assign take_jr     = active && !block && jr_valid;
    assign take_br     = active && !block && !jr_valid && br_valid && br_taken;
    assign redirect    = take_jr || take_br;
    assign redirect_pc = take_jr ? jr_aligned : br_target;

    assign inst_valid = (state == ST_FETCH) && !halt && !redirect && !stall && imem_valid;

    assign imem_req  = active;
    assign imem_addr = (state == ST_FETCH) ? pc :
                       (state == ST_DRAIN) ? drain_addr : '0;
    assign halted    = (state == ST_HALTED);
    assign pc_out    = pc;
    assign pc_plus2  = pc + STEP;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= ST_BOOT;
            pc         <= RESET_PC;
            drain_addr <= '0;
            halt_pend  <= 1'b0;
        end else begin
            case (state)
                ST_BOOT: begin
                    state <= ST_FETCH;
                end

                ST_FETCH: begin
                    if (halt) begin
                        state <= ST_HALTED;
                    end else if (redirect) begin
                        pc <= redirect_pc;
                        // A response arriving with the redirect closes the old request;
                        // otherwise wait for it with the old address still on the bus.
                        if (!imem_valid) begin
                            drain_addr <= pc;
                            state      <= ST_DRAIN;
                        end
                    end else if (inst_valid) begin
                        pc <= pc_plus2;
                    end
                end

                ST_DRAIN: begin
                    if (redirect) begin
                        pc <= redirect_pc;
                    end
                    if (halt) begin
                        halt_pend <= 1'b1;
                    end
                    if (imem_valid) begin
                        halt_pend <= 1'b0;
                        state     <= block ? ST_HALTED : ST_FETCH;
                    end
                end

                ST_HALTED: begin
                    state <= ST_HALTED;
                end

                default: begin
                    state <= ST_BOOT;
                end
            endcase
        end
    end

endmodule

// File: doc/pc_sequencer.md
Name: pc_sequencer

Overview:
Owns the 16-bit program counter and sequences instruction fetch for the basic CPU. Each cycle it picks the next PC from one of: sequential +2, conditional branch target, register-jump target, hold (stall), or freeze (halt). Drives a req/valid handshake to instruction memory and tells decode when a fetched word is usable. Sits between imem, decode and the hazard/branch-resolve logic.

Parameters:
RESET_PC, 16'h0000, PC value loaded on reset.
PC_STEP, 2, byte increment for sequential fetch.

Ports:
clk  in  1  system clock, rising edge.
rst  in  1  asynchronous, active-low reset (0 = reset).
imem_req  out  1  fetch request; held until imem_valid.
imem_addr  out  16  fetch address; equals pc, stable while imem_req=1.
imem_valid  in  1  fetch data returned this cycle.
stall  in  1  decode cannot accept; hold PC.
halt  in  1  HLT decoded; stop fetching.
br_valid  in  1  conditional branch resolving this cycle.
br_cond  in  3  condition code.
br_offset  in  9  signed word offset.
br_pc_plus2  in  16  PC+2 of the branch instruction.
flags  in  3  {Z,V,N} from flag register.
jr_valid  in  1  register jump resolving this cycle.
jr_target  in  16  jump target.
pc_out  out  16  current PC.
pc_plus2  out  16  pc_out+PC_STEP, mod 2^16.
inst_valid  out  1  fetched word accepted by decode this cycle.
redirect  out  1  flush younger instructions (combinational).
halted  out  1  sequencer frozen.

Behaviour:
- States: BOOT, FETCH, DRAIN, HALTED. Async reset -> BOOT, pc=RESET_PC, halted=0. All outputs 0 in reset except pc_out=RESET_PC, pc_plus2=RESET_PC+2.
- BOOT: one cycle, imem_req=0, -> FETCH.
- FETCH: imem_req=1, imem_addr=pc. Per-cycle priority: halt > jr_valid > taken branch > stall > imem_valid.
- halt=1: -> HALTED, pc holds, any response dropped.
- jr_valid=1: pc <= {jr_target[15:1],1'b0}; redirect=1.
- br_valid=1 and taken: pc <= br_pc_plus2 + (sext(br_offset)<<1), wrap mod 2^16; redirect=1. br_valid with not-taken: no effect.
- On redirect: if imem_valid same cycle, response dropped, stay FETCH. Otherwise -> DRAIN.
- stall=1 (no redirect/halt): pc holds, response dropped, request continues (refetch same address).
- imem_valid=1, nothing above: inst_valid=1, pc <= pc+PC_STEP (0xFFFE -> 0x0000).
- DRAIN: imem_req=1, imem_addr = the old address (held in a separate register). New pc already loaded. On imem_valid: drop it, -> FETCH. halt in DRAIN -> HALTED after the drain completes. A second redirect in DRAIN overwrites pc.
- HALTED: imem_req=0, halted=1, pc frozen. Exit only by reset.
- inst_valid=0 outside FETCH.
- Condition codes:
  - 000 NE: Z=0
  - 001 EQ: Z=1
  - 010 GT: Z=0 & N=0
  - 011 LT: N=1
  - 100 GE: Z=1 | N=0
  - 101 LE: N=1 | Z=1
  - 110 OVF: V=1
  - 111 UNCOND: always taken
- Reset asserted mid-fetch: immediate async return to BOOT. The in-flight request is abandoned; imem ignores it on reset.

Decomposition:
- cpu_pkg: state enum, COND_* 3-bit constants, flag bit indices (FLAG_Z=2, FLAG_V=1, FLAG_N=0), PC width.
- Sub-module branch_cond_eval: combinational; inputs br_cond and flags, output taken.
- Target adder, PC register and FSM stay in pc_sequencer.

Test Plan:
- Reset release, imem_valid every FETCH cycle -> BOOT 1 cycle, then imem_addr 0x0000, 0x0002, 0x0004; inst_valid=1 each cycle.
- pc=0xFFFE, imem_valid -> next pc 0x0000, pc_plus2 0x0002.
- br_valid, br_cond=001, Z=1, br_pc_plus2=0x0010, br_offset=9'h1FE (-2) -> pc=0x000C, redirect=1 one cycle. Same with Z=0 -> no redirect.
- jr_valid, jr_target=0x1235, no imem_valid -> pc=0x1234, DRAIN with imem_addr=old pc until imem_valid (dropped, inst_valid=0), then FETCH at 0x1234.
- stall=1 for 3 cycles with imem_valid -> pc unchanged, inst_valid=0; advances by 2 on first unstalled valid.
- halt=1 together with jr_valid -> HALTED, pc unchanged, imem_req=0. Reset low mid-DRAIN -> pc=RESET_PC, halted=0 asynchronously.
